// File: rtl/wire_ops_pkg.sv
// Shared types and constants for the WireOps self-checking driver.
package wire_ops_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Fibonacci taps at bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam logic [15:0] NO_ERR_IDX   = 16'hFFFF;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit left-shifting Fibonacci LFSR with synchronous load and advance.
module lfsr16
  import wire_ops_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        adv,
  output logic [15:0] q
);

  always_ff @(posedge sys_clk) begin
    if (sys_rst)   q <= 16'h0001;
    else if (load) q <= seed;
    else if (adv)  q <= lfsr_next(q);
  end

endmodule

// File: rtl/wire_ops_driver.sv
// Pseudo-random stimulus generator and one-cycle-delayed checker for WireOps.
module wire_ops_driver
  import wire_ops_pkg::*;
#(
  parameter int          WIDTH = 8,
  parameter logic [15:0] SEED  = DEFAULT_SEED
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [15:0]      count,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             sel,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [15:0]      first_err_idx
);

  // an all-zero seed would lock the LFSR
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  state_t           state, state_nxt;
  logic [15:0]      lfsr_q;
  logic [15:0]      remaining;
  logic [15:0]      idx;
  logic [WIDTH-1:0] exp_q;
  logic             exp_vld_q;
  logic [15:0]      exp_idx_q;
  logic             accept;
  logic             run;

  lfsr16 u_lfsr (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .load    (accept && (count != 16'd0)),
    .seed    (SEED_EFF),
    .adv     (run),
    .q       (lfsr_q)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (count == 16'd0) ? DONE : RUN;
        end
      end
      RUN:     if (remaining == 16'd1) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    run  = (state == RUN);
    a    = run ? lfsr_q[WIDTH-1:0]       : '0;
    b    = run ? lfsr_q[2*WIDTH-1:WIDTH] : '0;
    sel  = run ? lfsr_q[0]               : 1'b0;
    busy = run || (state == DRAIN);
    done = (state == DONE);
    pass = done && (err_count == 16'd0);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      remaining     <= 16'd0;
      idx           <= 16'd0;
      exp_q         <= '0;
      exp_vld_q     <= 1'b0;
      exp_idx_q     <= 16'd0;
      err_count     <= 16'd0;
      first_err_idx <= NO_ERR_IDX;
    end else begin
      exp_vld_q <= run;
      if (run) begin
        exp_q     <= sel ? (a & b) : (a ^ b);
        exp_idx_q <= idx;
        idx       <= idx + 16'd1;
        remaining <= remaining - 16'd1;
      end
      if (accept) begin
        remaining     <= count;
        idx           <= 16'd0;
        err_count     <= 16'd0;
        first_err_idx <= NO_ERR_IDX;
      end else if (exp_vld_q && (y != exp_q)) begin
        if (err_count != 16'hFFFF)       err_count     <= err_count + 16'd1;
        if (first_err_idx == NO_ERR_IDX) first_err_idx <= exp_idx_q;
      end
    end
  end

endmodule

// File: tb/tb_wire_ops_driver.sv
// Randomized loopback bench for wire_ops_driver with a behavioural WireOps and reference model.
module tb_wire_ops_driver;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        start;
  logic [15:0] count;
  logic [7:0]  a, b, y;
  logic        sel;
  logic        busy, done, pass;
  logic [15:0] err_count, first_err_idx;

  int total = 0;
  int bad   = 0;

  logic [7:0] xmask [0:255];
  bit         stuck  = 1'b0;
  int         cur_idx = -1;

  wire_ops_driver dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .start         (start),
    .count         (count),
    .a             (a),
    .b             (b),
    .sel           (sel),
    .y             (y),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_idx (first_err_idx)
  );

  always #5 sys_clk = ~sys_clk;

  // Stand-in unit under test: registered AND/XOR with injectable corruption.
  initial y = 8'h00;
  always @(posedge sys_clk) begin
    logic [7:0] r;
    r = sel ? (a & b) : (a ^ b);
    if (stuck)                              y <= 8'hFF;
    else if (cur_idx >= 0 && cur_idx < 256) y <= r ^ xmask[cur_idx];
    else                                    y <= r;
  end

  function automatic logic [15:0] ref_step(input logic [15:0] l);
    logic fb;
    fb = l[15] ^ l[13] ^ l[12] ^ l[10];
    return {l[14:0], fb};
  endfunction

  task automatic clear_mask();
    for (int i = 0; i < 256; i++) xmask[i] = 8'h00;
  endtask

  // Issues one run from IDLE/DONE and checks every cycle against the model.
  task automatic run_vectors(input int n, input int restart_at,
                             output logic [7:0] a0, output logic [7:0] b0,
                             output logic sel0);
    logic [15:0] l;
    logic [15:0] first;
    logic [7:0]  ea, eb, ey, ry;
    logic        es;
    int          errs;
    l = 16'hACE1; first = 16'hFFFF; errs = 0;
    a0 = 8'h00; b0 = 8'h00; sel0 = 1'b0;
    @(negedge sys_clk);
    start = 1'b1; count = 16'(n);
    @(negedge sys_clk);
    start = 1'b0;
    if (n == 0) begin
      total++;
      if ({done, pass, busy, err_count, first_err_idx} !== {3'b110, 16'h0000, 16'hFFFF}) begin
        bad++;
        $display("FAIL zero_count_status: got done=%b pass=%b busy=%b err=%h first=%h want 1 1 0 0000 ffff",
                 done, pass, busy, err_count, first_err_idx);
      end
      total++;
      if ({a, b, sel} !== 17'h0) begin
        bad++;
        $display("FAIL zero_count_ops: got a=%h b=%h sel=%b want 0", a, b, sel);
      end
      return;
    end
    for (int c = 1; c <= n; c++) begin
      start   = 1'b0;
      cur_idx = c - 1;
      ea = l[7:0]; eb = l[15:8]; es = l[0];
      ey = es ? (ea & eb) : (ea ^ eb);
      ry = stuck ? 8'hFF : (ey ^ xmask[c-1]);
      if (ry != ey) begin
        if (first == 16'hFFFF) first = 16'(c - 1);
        errs++;
      end
      total++;
      if ({a, b, sel} !== {ea, eb, es}) begin
        bad++;
        $display("FAIL run_operands[%0d]: got a=%h b=%h sel=%b want a=%h b=%h sel=%b",
                 c - 1, a, b, sel, ea, eb, es);
      end
      total++;
      if ({busy, done} !== 2'b10) begin
        bad++;
        $display("FAIL run_status[%0d]: got busy=%b done=%b want 1 0", c - 1, busy, done);
      end
      if (c == 1) begin a0 = a; b0 = b; sel0 = sel; end
      if (c == restart_at) begin start = 1'b1; count = 16'd3; end
      l = ref_step(l);
      @(negedge sys_clk);
    end
    start   = 1'b0;
    cur_idx = -1;
    total++;
    if ({busy, done, a, b, sel} !== {2'b10, 17'h0}) begin
      bad++;
      $display("FAIL drain: got busy=%b done=%b a=%h b=%h sel=%b want 1 0 00 00 0",
               busy, done, a, b, sel);
    end
    if (restart_at == n + 1) begin start = 1'b1; count = 16'd3; end
    @(negedge sys_clk);
    start = 1'b0;
    total++;
    if ({done, busy, pass} !== {2'b10, errs == 0}) begin
      bad++;
      $display("FAIL done_status: got done=%b busy=%b pass=%b want 1 0 %b", done, busy, pass, errs == 0);
    end
    total++;
    if ({err_count, first_err_idx} !== {16'(errs), first}) begin
      bad++;
      $display("FAIL results: got err=%0d first=%h want err=%0d first=%h", err_count, first_err_idx, errs, first);
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; start = 1'b0; count = 16'd0;
    repeat (3) @(negedge sys_clk);
    total++;
    if ({busy, done, pass, a, b, sel, err_count, first_err_idx} !== {3'b000, 17'h0, 16'h0000, 16'hFFFF}) begin
      bad++;
      $display("FAIL reset_state: got busy=%b done=%b pass=%b a=%h b=%h sel=%b err=%h first=%h",
               busy, done, pass, a, b, sel, err_count, first_err_idx);
    end
    sys_rst = 1'b0;
    @(negedge sys_clk);
    total++;
    if ({busy, done, a, b, sel} !== {2'b00, 17'h0}) begin
      bad++;
      $display("FAIL idle_after_reset: got busy=%b done=%b a=%h b=%h sel=%b want all 0", busy, done, a, b, sel);
    end
  endtask

  task automatic test_single();
    logic [7:0] a0, b0;
    logic       s0;
    clear_mask();
    run_vectors(1, 0, a0, b0, s0);
    total++;
    if ({a0, b0, s0} !== {8'hE1, 8'hAC, 1'b1}) begin
      bad++;
      $display("FAIL single_operands: got a=%h b=%h sel=%b want e1 ac 1", a0, b0, s0);
    end
    total++;
    if (pass !== 1'b1) begin
      bad++;
      $display("FAIL single_pass: got %b want 1", pass);
    end
    stuck = 1'b1;
    run_vectors(1, 0, a0, b0, s0);
    stuck = 1'b0;
    total++;
    if ({err_count, first_err_idx, pass} !== {16'd1, 16'd0, 1'b0}) begin
      bad++;
      $display("FAIL single_stuck: got err=%0d first=%h pass=%b want 1 0000 0", err_count, first_err_idx, pass);
    end
  endtask

  task automatic test_zero_count();
    logic [7:0] a0, b0;
    logic       s0;
    run_vectors(0, 0, a0, b0, s0);
  endtask

  task automatic test_loopback_100();
    logic [7:0] a0, b0;
    logic       s0;
    clear_mask();
    run_vectors(100, 0, a0, b0, s0);
    total++;
    if ({pass, err_count, first_err_idx} !== {1'b1, 16'h0000, 16'hFFFF}) begin
      bad++;
      $display("FAIL loopback_100: got pass=%b err=%h first=%h want 1 0000 ffff", pass, err_count, first_err_idx);
    end
  endtask

  task automatic test_invert_from5();
    logic [7:0] a0, b0;
    logic       s0;
    clear_mask();
    for (int i = 5; i < 256; i++) xmask[i] = 8'hFF;
    run_vectors(10, 0, a0, b0, s0);
    clear_mask();
    total++;
    if ({err_count, first_err_idx} !== {16'd5, 16'd5}) begin
      bad++;
      $display("FAIL invert_from5: got err=%0d first=%0d want 5 5", err_count, first_err_idx);
    end
  endtask

  task automatic test_random();
    logic [7:0] a0, b0;
    logic       s0;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 256; i++)
        xmask[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run_vectors(int'($urandom_range(1, 40)), 0, a0, b0, s0);
    end
    clear_mask();
  endtask

  task automatic test_start_ignored();
    logic [7:0] a0, b0;
    logic       s0;
    clear_mask();
    xmask[2] = 8'h10;
    run_vectors(12, 3, a0, b0, s0);
    run_vectors(6, 7, a0, b0, s0);
    clear_mask();
  endtask

  task automatic test_back_to_back();
    logic [7:0] a0, b0, a1, b1;
    logic       s0, s1;
    clear_mask();
    run_vectors(8, 0, a0, b0, s0);
    run_vectors(8, 0, a1, b1, s1);
    total++;
    if ({a1, b1, s1} !== {8'hE1, 8'hAC, 1'b1}) begin
      bad++;
      $display("FAIL rerun_first_vector: got a=%h b=%h sel=%b want e1 ac 1", a1, b1, s1);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] a0, b0;
    logic       s0;
    clear_mask();
    xmask[0] = 8'h01; xmask[1] = 8'h80; xmask[2] = 8'h3C;
    @(negedge sys_clk);
    start = 1'b1; count = 16'd20;
    @(negedge sys_clk);
    start = 1'b0;
    for (int c = 1; c < 4; c++) begin
      cur_idx = c - 1;
      @(negedge sys_clk);
    end
    cur_idx = 3;
    total++;
    if (err_count !== 16'd2) begin
      bad++;
      $display("FAIL pre_reset_errs: got %0d want 2", err_count);
    end
    sys_rst = 1'b1;
    @(negedge sys_clk);
    cur_idx = -1;
    total++;
    if ({busy, done, pass, a, b, sel, err_count, first_err_idx} !== {3'b000, 17'h0, 16'h0000, 16'hFFFF}) begin
      bad++;
      $display("FAIL reset_mid_run: got busy=%b done=%b pass=%b a=%h b=%h sel=%b err=%h first=%h",
               busy, done, pass, a, b, sel, err_count, first_err_idx);
    end
    sys_rst = 1'b0;
    clear_mask();
    run_vectors(20, 0, a0, b0, s0);
  endtask

  initial begin
    clear_mask();
    test_reset();
    test_single();
    test_zero_count();
    test_loopback_100();
    test_invert_from5();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
